// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, memory freezes and branch redirects
// for a five-stage pipeline. Define HAZARD_PERF_CNT_EN to add stall/flush counters.
module hazard_ctrl #(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_id_valid,
  input  logic [6:0]             if_id_opcode,
  input  logic [4:0]             if_id_rs1_s,
  input  logic [4:0]             if_id_rs2_s,
  input  logic                   id_ex_valid,
  input  logic [6:0]             id_ex_opcode,
  input  logic [4:0]             id_ex_rd_s,
  input  logic                   ex_br_taken,
  input  logic                   imem_pending,
  input  logic                   imem_resp,
  input  logic                   dmem_wait,
  output logic                   pc_we,
  output logic                   if_id_we,
  output logic                   id_ex_we,
  output logic                   ex_mem_we,
  output logic                   mem_wb_we,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
`ifdef HAZARD_PERF_CNT_EN
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [STALL_CNT_W-1:0] flush_cnt,
`endif
  output logic [1:0]             state_o
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic uses_rs1, uses_rs2, load_use, imem_stall;
  logic pc_we_c, if_id_we_c, id_ex_we_c, ex_mem_we_c, mem_wb_we_c;
  logic if_id_flush_c, id_ex_flush_c;

  always_comb begin
    uses_rs1 = (if_id_opcode == OP_JALR) || (if_id_opcode == OP_BR) ||
               (if_id_opcode == OP_LOAD) || (if_id_opcode == OP_STORE) ||
               (if_id_opcode == OP_IMM)  || (if_id_opcode == OP_REG);
    uses_rs2 = (if_id_opcode == OP_BR) || (if_id_opcode == OP_STORE) ||
               (if_id_opcode == OP_REG);
    load_use = id_ex_valid && (id_ex_opcode == OP_LOAD) && (id_ex_rd_s != 5'd0) &&
               if_id_valid &&
               ((uses_rs1 && (if_id_rs1_s == id_ex_rd_s)) ||
                (uses_rs2 && (if_id_rs2_s == id_ex_rd_s)));
    imem_stall = imem_pending && !imem_resp;
  end

  always_comb begin
    pc_we_c       = 1'b1;
    if_id_we_c    = 1'b1;
    id_ex_we_c    = 1'b1;
    ex_mem_we_c   = 1'b1;
    mem_wb_we_c   = 1'b1;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    state_nxt     = state;
    case (state)
      // MEM_WAIT differs from RUN only in reporting; once dmem_wait drops the RUN rules apply.
      RUN, MEM_WAIT: begin
        if (dmem_wait) begin
          pc_we_c     = 1'b0;
          if_id_we_c  = 1'b0;
          id_ex_we_c  = 1'b0;
          ex_mem_we_c = 1'b0;
          mem_wb_we_c = 1'b0;
          state_nxt   = MEM_WAIT;
        end else if (ex_br_taken) begin
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
          state_nxt     = imem_stall ? REDIRECT : RUN;
        end else if (load_use) begin
          pc_we_c       = 1'b0;
          if_id_we_c    = 1'b0;
          id_ex_flush_c = 1'b1;
          state_nxt     = RUN;
        end else if (imem_stall) begin
          pc_we_c       = 1'b0;
          if_id_flush_c = 1'b1;
          state_nxt     = RUN;
        end else begin
          state_nxt = RUN;
        end
      end
      // Wrong-path fetch still in flight: discard whatever arrives, EX holds a bubble.
      REDIRECT: begin
        pc_we_c       = imem_resp;
        if_id_flush_c = 1'b1;
        id_ex_we_c    = !dmem_wait;
        ex_mem_we_c   = !dmem_wait;
        mem_wb_we_c   = !dmem_wait;
        state_nxt     = imem_resp ? RUN : REDIRECT;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Outputs are forced quiet while reset is held; a flush never fires into a frozen register.
  assign pc_we       = rst_n && pc_we_c;
  assign if_id_we    = rst_n && if_id_we_c;
  assign id_ex_we    = rst_n && id_ex_we_c;
  assign ex_mem_we   = rst_n && ex_mem_we_c;
  assign mem_wb_we   = rst_n && mem_wb_we_c;
  assign if_id_flush = if_id_we && if_id_flush_c;
  assign id_ex_flush = id_ex_we && id_ex_flush_c;
  assign state_o     = state;

`ifdef HAZARD_PERF_CNT_EN
  logic redirect_acc;
  assign redirect_acc = (state != REDIRECT) && !dmem_wait && ex_br_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_we && (stall_cnt != {STALL_CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (redirect_acc && (flush_cnt != {STALL_CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; counters are checked when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic if_id_valid, id_ex_valid;
  logic [6:0] if_id_opcode, id_ex_opcode;
  logic [4:0] if_id_rs1_s, if_id_rs2_s, id_ex_rd_s;
  logic ex_br_taken, imem_pending, imem_resp, dmem_wait;
  logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush;
  logic [1:0] state_o;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.STALL_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_valid(if_id_valid), .if_id_opcode(if_id_opcode),
    .if_id_rs1_s(if_id_rs1_s), .if_id_rs2_s(if_id_rs2_s),
    .id_ex_valid(id_ex_valid), .id_ex_opcode(id_ex_opcode), .id_ex_rd_s(id_ex_rd_s),
    .ex_br_taken(ex_br_taken), .imem_pending(imem_pending), .imem_resp(imem_resp),
    .dmem_wait(dmem_wait),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
    .mem_wb_we(mem_wb_we), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .state_o(state_o)
  );

`ifndef HAZARD_PERF_CNT_EN
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  // {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush}
  localparam logic [6:0] E_IDLE = 7'h7c, E_LU = 7'h1d, E_FRZ = 7'h00, E_BR = 7'h7f;
  localparam logic [6:0] E_IWAIT = 7'h3e, E_RESP = 7'h7e, E_RDW = 7'h22;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_REG = 7'b0110011;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_STORE = 7'b0100011, OP_IMM = 7'b0010011;

  wire [6:0] outs = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush};

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    if_id_valid = 1'b0; if_id_opcode = OP_IMM; if_id_rs1_s = '0; if_id_rs2_s = '0;
    id_ex_valid = 1'b0; id_ex_opcode = OP_IMM; id_ex_rd_s = '0;
    ex_br_taken = 1'b0; imem_pending = 1'b0; imem_resp = 1'b0; dmem_wait = 1'b0;
  endtask

  task automatic ctl(input logic br, input logic dw, input logic pend, input logic resp);
    ex_br_taken = br; dmem_wait = dw; imem_pending = pend; imem_resp = resp;
  endtask

  // Call just after a falling edge with inputs applied; checks this cycle, then counters.
  task automatic cyc(input string tag, input logic [6:0] e, input logic [1:0] st);
    #1;
    chk({tag, "/we"}, {25'd0, outs}, {25'd0, e});
    chk({tag, "/st"}, {30'd0, state_o}, {30'd0, st});
    @(posedge clk);
    if (!rst_n) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (!e[6] && exp_stall < 15) exp_stall++;
      if (e == E_BR && exp_flush < 15) exp_flush++;
    end
`ifdef HAZARD_PERF_CNT_EN
    #1;
    chk({tag, "/stall_cnt"}, {28'd0, stall_cnt}, exp_stall);
    chk({tag, "/flush_cnt"}, {28'd0, flush_cnt}, exp_flush);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    @(negedge clk); cyc("reset", E_FRZ, 2'd0);
    @(negedge clk); rst_n = 1'b1; cyc("idle", E_IDLE, 2'd0);

    // lw x5 ; add x6,x5,x7 -> one bubble
    @(negedge clk);
    id_ex_valid = 1'b1; id_ex_opcode = OP_LOAD; id_ex_rd_s = 5'd5;
    if_id_valid = 1'b1; if_id_opcode = OP_REG; if_id_rs1_s = 5'd5; if_id_rs2_s = 5'd7;
    cyc("lu_rs1", E_LU, 2'd0);
    @(negedge clk); id_ex_valid = 1'b0; cyc("lu_after", E_IDLE, 2'd0);
    @(negedge clk); id_ex_valid = 1'b1; id_ex_rd_s = 5'd0; if_id_rs1_s = 5'd0;
    cyc("lu_x0", E_IDLE, 2'd0);
    @(negedge clk); id_ex_rd_s = 5'd9; if_id_opcode = OP_LUI; if_id_rs1_s = 5'd9; if_id_rs2_s = 5'd9;
    cyc("lu_lui", E_IDLE, 2'd0);
    @(negedge clk); if_id_opcode = OP_STORE; if_id_rs1_s = 5'd1;
    cyc("lu_st_rs2", E_LU, 2'd0);
    @(negedge clk); if_id_opcode = OP_IMM;
    cyc("lu_imm_rs2", E_IDLE, 2'd0);
    @(negedge clk); if_id_valid = 1'b0; if_id_rs1_s = 5'd9;
    cyc("lu_ifvalid0", E_IDLE, 2'd0);

    // four-cycle data memory freeze
    @(negedge clk); clr(); ctl(0, 1, 0, 0); cyc("dw1", E_FRZ, 2'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); cyc("dwN", E_FRZ, 2'd1);
    end
    @(negedge clk); ctl(0, 0, 0, 0); cyc("dw_rel", E_IDLE, 2'd1);
    @(negedge clk); cyc("dw_done", E_IDLE, 2'd0);

    // taken branch with fetch outstanding, response on the third cycle
    @(negedge clk); ctl(1, 0, 1, 0); cyc("br_pend", E_BR, 2'd0);
    @(negedge clk); ctl(0, 0, 1, 0); cyc("rd1", E_IWAIT, 2'd2);
    @(negedge clk); ctl(1, 0, 1, 0);
    id_ex_valid = 1'b1; id_ex_opcode = OP_LOAD; id_ex_rd_s = 5'd3;
    if_id_valid = 1'b1; if_id_opcode = OP_REG; if_id_rs1_s = 5'd3;
    cyc("rd2_ignore", E_IWAIT, 2'd2);
    @(negedge clk); clr(); ctl(0, 0, 1, 1); cyc("rd3_resp", E_RESP, 2'd2);
    @(negedge clk); ctl(0, 0, 0, 0); cyc("rd_exit", E_IDLE, 2'd0);

    // branch without pending fetch, branch beating load-use, fetch stall alone
    @(negedge clk); ctl(1, 0, 0, 0); cyc("br_nopend", E_BR, 2'd0);
    @(negedge clk);
    id_ex_valid = 1'b1; id_ex_opcode = OP_LOAD; id_ex_rd_s = 5'd4;
    if_id_valid = 1'b1; if_id_opcode = OP_REG; if_id_rs2_s = 5'd4;
    cyc("br_lu", E_BR, 2'd0);
    @(negedge clk); clr(); ctl(0, 0, 1, 0); cyc("ifetch", E_IWAIT, 2'd0);
    @(negedge clk); ctl(0, 0, 1, 1); cyc("ifetch_resp", E_IDLE, 2'd0);

    // branch and freeze together: freeze first, branch accepted on release
    @(negedge clk); ctl(1, 1, 0, 0); cyc("br_dw", E_FRZ, 2'd0);
    @(negedge clk); ctl(1, 0, 0, 0); cyc("br_dw_rel", E_BR, 2'd1);
    @(negedge clk); ctl(0, 0, 0, 0); cyc("br_dw_done", E_IDLE, 2'd0);

    // freeze inside REDIRECT
    @(negedge clk); ctl(1, 0, 1, 0); cyc("br2", E_BR, 2'd0);
    @(negedge clk); ctl(0, 1, 1, 0); cyc("rd_dw", E_RDW, 2'd2);
    @(negedge clk); ctl(0, 0, 1, 1); cyc("rd_dw_resp", E_RESP, 2'd2);

    // reset while in REDIRECT
    @(negedge clk); ctl(1, 0, 1, 0); cyc("br3", E_BR, 2'd0);
    @(negedge clk); ctl(0, 0, 1, 0); rst_n = 1'b0; cyc("rst_redir", E_FRZ, 2'd0);
    @(negedge clk); rst_n = 1'b1; ctl(0, 0, 0, 0); cyc("rst_rel", E_IDLE, 2'd0);

    // counter saturation over twenty fetch-stall cycles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); ctl(0, 0, 1, 0); cyc("sat", E_IWAIT, 2'd0);
    end
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_sat", {28'd0, stall_cnt}, 32'd15);
`endif
    @(negedge clk); clr(); cyc("final", E_IDLE, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: STALL_CNT_W, 32, width of the performance counters.
REQ-002 Port: clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst_n  in  1  asynchronous active-low reset.
REQ-004 Port: if_id_valid / if_id_opcode / if_id_rs1_s / if_id_rs2_s  in  1/7/5/5  instruction in ID.
REQ-005 Port: id_ex_valid / id_ex_opcode / id_ex_rd_s  in  1/7/5  instruction in EX.
REQ-006 Port: ex_br_taken  in  1  EX resolved a taken branch/jal/jalr; PC redirect required.
REQ-007 Port: imem_pending / imem_resp  in  1/1  fetch request outstanding / fetch response this cycle.
REQ-008 Port: dmem_wait  in  1  MEM-stage access outstanding without response.
REQ-009 Port: pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1 each  stage register enables.
REQ-010 Port: if_id_flush, id_ex_flush  out  1 each  load nop 0x00000013 with valid=0 into the stage.
REQ-011 Port: state_o  out  2  RUN=0, MEM_WAIT=1, REDIRECT=2.

Function
REQ-012 The FSM SHALL have states RUN, MEM_WAIT and REDIRECT; outputs are Mealy (state plus current inputs).
REQ-013 Default with no condition active: all *_we=1, flushes=0.
REQ-014 load_use SHALL be id_ex_valid & id_ex_opcode==load & id_ex_rd_s!=0 & if_id_valid & ((uses_rs1 & rs1==rd) | (uses_rs2 & rs2==rd)).
REQ-015 uses_rs1 = jalr, br, load, store, imm, reg; uses_rs2 = br, store, reg; lui/auipc/jal use neither.
REQ-016 RUN priority 1, dmem_wait=1: all five *_we=0, flushes=0; next MEM_WAIT.
REQ-017 RUN priority 2, ex_br_taken=1: all *_we=1, if_id_flush=1, id_ex_flush=1; next REDIRECT if imem_pending & !imem_resp, else RUN.
REQ-018 RUN priority 3, load_use=1: pc_we=0, if_id_we=0, id_ex_flush=1, rest we=1; stay RUN (one bubble).
REQ-019 RUN priority 4, imem_pending & !imem_resp: pc_we=0, if_id_flush=1, downstream we=1; stay RUN.
REQ-020 MEM_WAIT: all *_we=0 while dmem_wait=1; first cycle dmem_wait=0, apply RUN rules that cycle; next RUN or REDIRECT per REQ-017.
REQ-021 REDIRECT: pc_we=0, if_id_flush=1 (stale wrong-path response discarded); id_ex/ex_mem/mem_wb_we=!dmem_wait.
REQ-022 REDIRECT exit: on imem_resp=1, pc_we=1 and next RUN; ex_br_taken in REDIRECT is ignored (EX holds a bubble).
REQ-023 Simultaneous dmem_wait and ex_br_taken: freeze wins; branch re-evaluated after release.
REQ-024 Simultaneous ex_br_taken and load_use: redirect wins; no load-use stall.
REQ-025 Any enable cleared by freeze SHALL be 0 even if a flush is asserted; flush outputs 0 when the target we=0.

Reset
REQ-026 While rst_n=0: state RUN, all *_we=0, all flushes=0, state_o=0, counters 0.
REQ-027 Reset asserted mid-MEM_WAIT or mid-REDIRECT SHALL abandon the state immediately; first cycle after release is RUN.

Configuration
REQ-028 With HAZARD_PERF_CNT_EN defined: outputs stall_cnt, flush_cnt (STALL_CNT_W each, registered).
REQ-029 stall_cnt +1 per cycle with rst_n=1 and pc_we=0; flush_cnt +1 per accepted redirect (REQ-017); both saturate at all-ones.
REQ-030 Without HAZARD_PERF_CNT_EN: ports and counter logic absent; all other behaviour identical.

Verification
REQ-031 lw x5 in EX, add x6,x5,x7 in ID -> exactly one cycle pc_we=0, if_id_we=0, id_ex_flush=1; same with rd=x0 -> no stall.
REQ-032 dmem_wait high 4 cycles -> all *_we=0 for those 4 cycles, state_o=1, then 0.
REQ-033 ex_br_taken with imem_pending=1, imem_resp after 3 cycles -> both flushes one cycle, state_o=2 for 3 cycles, if_id_flush=1 throughout, pc_we=1 on the resp cycle.
REQ-034 ex_br_taken and dmem_wait same cycle -> freeze only; flush_cnt unchanged; redirect taken on release.
REQ-035 rst_n low during REDIRECT -> outputs 0 within reset; after release state_o=0 and counters 0 (macro on).
REQ-036 Macro on, STALL_CNT_W=4, 20 stall cycles -> stall_cnt holds 15.
